// File: rtl/sort_pkg.sv
// Shared definitions for the sequential bubble-sort controller.
package sort_pkg;

  localparam int unsigned DEPTH_MAX = 16;
  localparam int unsigned IDX_W     = $clog2(DEPTH_MAX);

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StSort   = 2'd1,
    StUnload = 2'd2
  } state_e;

endpackage

// File: rtl/comp_8.sv
// Purely combinational 8-bit unsigned magnitude comparator.
module comp_8 (
  input  logic [7:0] i_data_in1,
  input  logic [7:0] i_data_in2,
  output logic       o_gt,
  output logic       o_eq,
  output logic       o_lt
);

  always_comb begin
    o_gt = (i_data_in1 > i_data_in2);
    o_eq = (i_data_in1 == i_data_in2);
    o_lt = (i_data_in1 < i_data_in2);
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Loads a DEPTH-byte burst, bubble-sorts it one compare-and-swap per cycle through a
// single shared comparator, then streams it out smallest first.
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  output logic       o_busy,
  output logic [7:0] o_swap_count
);

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_wr_idx, r_rd_idx, r_pass, r_j;
  logic             r_pass_swapped;
  logic [7:0]       r_swap_count;
  logic [7:0]       r_mem [DEPTH];

  logic [IDX_W-1:0] w_j1, w_j_last;
  logic [7:0]       w_a, w_b, w_rd_data;
  logic             w_gt, w_eq, w_lt;
  logic             w_in_hs, w_out_hs, w_load_last, w_rd_last, w_pass_end, w_swapped_now;

  assign w_j1          = r_j + IDX_W'(1);
  assign w_j_last      = IDX_W'(DEPTH - 2) - r_pass;
  assign w_in_hs       = i_in_valid && (r_state == StLoad);
  assign w_out_hs      = i_out_ready && (r_state == StUnload);
  assign w_load_last   = (r_wr_idx == IDX_W'(DEPTH - 1));
  assign w_rd_last     = (r_rd_idx == IDX_W'(DEPTH - 1));
  assign w_pass_end    = (r_j == w_j_last);
  assign w_swapped_now = r_pass_swapped | w_gt;
  assign o_swap_count  = r_swap_count;

  // Explicit compare-select muxes keep index widths independent of DEPTH.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_rd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (IDX_W'(i) == r_j)      w_a       = r_mem[i];
      if (IDX_W'(i) == w_j1)     w_b       = r_mem[i];
      if (IDX_W'(i) == r_rd_idx) w_rd_data = r_mem[i];
    end
  end

  comp_8 u_cmp (
    .i_data_in1 (w_a),
    .i_data_in2 (w_b),
    .o_gt       (w_gt),
    .o_eq       (w_eq),
    .o_lt       (w_lt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StLoad;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_out_data   = '0;
    o_out_last   = 1'b0;
    o_busy       = 1'b1;
    unique case (r_state)
      StLoad: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (w_in_hs && w_load_last) w_state_next = StSort;
      end
      StSort: begin
        // Early exit once a full pass makes no swap, or after the final pass.
        if (w_pass_end && (!w_swapped_now || r_pass == IDX_W'(DEPTH - 2))) begin
          w_state_next = StUnload;
        end
      end
      StUnload: begin
        o_out_valid = 1'b1;
        o_out_data  = w_rd_data;
        o_out_last  = w_rd_last;
        if (w_out_hs && w_rd_last) w_state_next = StLoad;
      end
      default: w_state_next = StLoad;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_pass         <= '0;
      r_j            <= '0;
      r_pass_swapped <= 1'b0;
      r_swap_count   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (w_in_hs) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (IDX_W'(i) == r_wr_idx) r_mem[i] <= i_in_data;
            end
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (w_load_last) begin
              r_pass         <= '0;
              r_j            <= '0;
              r_pass_swapped <= 1'b0;
              r_swap_count   <= '0;
            end
          end
        end
        StSort: begin
          if (w_gt) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (IDX_W'(i) == r_j)  r_mem[i] <= w_b;
              if (IDX_W'(i) == w_j1) r_mem[i] <= w_a;
            end
            r_swap_count <= r_swap_count + 8'd1;
          end
          if (w_pass_end) begin
            r_j            <= '0;
            r_pass         <= r_pass + IDX_W'(1);
            r_pass_swapped <= 1'b0;
          end else begin
            r_j            <= w_j1;
            r_pass_swapped <= w_swapped_now;
          end
        end
        StUnload: begin
          if (w_out_hs) begin
            if (w_rd_last) begin
              r_rd_idx <= '0;
              r_wr_idx <= '0;
            end else begin
              r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl: sorted bytes queued at stimulus time, popped on output.
module tb_sort_seq_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_rst, i_in_valid, i_out_ready;
  logic [7:0] i_in_data;
  logic       o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [7:0] o_out_data, o_swap_count;

  logic [8:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sort_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_out_last   (o_out_last),
    .o_busy       (o_busy),
    .o_swap_count (o_swap_count)
  );

  // Reference: selection sort for order, inversion count for bubble-swap total.
  task automatic model_push(input logic [31:0] burst, output int swaps);
    logic [7:0] a [4];
    logic [7:0] t;
    swaps = 0;
    for (int k = 0; k < 4; k++) a[k] = burst[31-8*k -: 8];
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (a[i] > a[j]) swaps++;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 4; j++)
        if (a[j] < a[i]) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3) ? 1'b1 : 1'b0, a[k]});
  endtask

  task automatic run_burst(input string name, input logic [31:0] burst, input bit bp,
                           input bit pulse, input int exp_cyc);
    int         exp_sw, sent, got, cyc, sort_cyc;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [8:0] e;
    model_push(burst, exp_sw);
    sent = 0; got = 0; cyc = 0; sort_cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_vec++;
        if (o_in_ready !== 1'b1) begin
          n_err++; $display("FAIL %s ready_at_start: got %b want 1", name, o_in_ready);
        end
      end
      i_out_ready = bp ? cyc[0] : 1'b1;
      if (sent < 4) begin
        i_in_valid = 1'b1;
        i_in_data  = burst[31-8*sent -: 8];
      end else begin
        i_in_valid = pulse && o_out_valid;
        i_in_data  = 8'hAA;
      end
      if (o_busy && !o_out_valid) sort_cyc++;
      if (sent < 4) begin
        if (o_in_ready) sent++;
      end else if (i_in_valid) begin
        n_vec++;
        if (o_in_ready !== 1'b0) begin
          n_err++; $display("FAIL %s busy_input_ignored: in_ready got %b want 0", name, o_in_ready);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (o_out_valid !== 1'b1 || o_out_data !== prev_data) begin
          n_err++;
          $display("FAIL %s hold: valid %b data %0d want valid 1 data %0d",
                   name, o_out_valid, o_out_data, prev_data);
        end
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_data  = o_out_data;
      if (o_out_valid && i_out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s extra_output: got %0d want none", name, o_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({o_out_last, o_out_data} !== e) begin
            n_err++;
            $display("FAIL %s out[%0d]: got last %b data %0d want last %b data %0d",
                     name, got, o_out_last, o_out_data, e[8], e[7:0]);
          end
        end
        got++;
      end
    end
    if (got < 4) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: got %0d outputs want 4", name, got);
      exp_q.delete();
    end
    n_vec++;
    if (o_swap_count !== 8'(exp_sw)) begin
      n_err++; $display("FAIL %s swap_count: got %0d want %0d", name, o_swap_count, exp_sw);
    end
    if (exp_cyc >= 0) begin
      n_vec++;
      if (sort_cyc != exp_cyc) begin
        n_err++; $display("FAIL %s sort_cycles: got %0d want %0d", name, sort_cyc, exp_cyc);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    n_vec++;
    if ({o_in_ready, o_out_valid, o_out_last, o_busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/vld/last/busy %b want 1000",
               {o_in_ready, o_out_valid, o_out_last, o_busy});
    end
    n_vec++;
    if (o_out_data !== 8'd0 || o_swap_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_data: got data %0d swaps %0d want 0 0", o_out_data, o_swap_count);
    end
  endtask

  task automatic test_sort_patterns();
    run_burst("mixed",     {8'd69, 8'd96, 8'd99, 8'd69},   1'b0, 1'b0, 6);
    run_burst("presorted", {8'd1, 8'd2, 8'd3, 8'd4},       1'b0, 1'b0, 3);
    run_burst("reverse",   {8'd200, 8'd150, 8'd100, 8'd50}, 1'b0, 1'b0, 6);
  endtask

  task automatic test_backpressure();
    run_burst("backpressure", {8'd5, 8'd0, 8'd255, 8'd5}, 1'b1, 1'b1, 5);
  endtask

  task automatic test_reset_mid_sort();
    logic [31:0] b;
    b = {8'd9, 8'd8, 8'd7, 8'd6};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_in_valid = 1'b1; i_in_data = b[31-8*k -: 8]; i_out_ready = 1'b1;
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1 || o_out_valid !== 1'b0) begin
      n_err++; $display("FAIL sort_entry: got busy %b valid %b want 1 0", o_busy, o_out_valid);
    end
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    n_vec++;
    if ({o_busy, o_in_ready, o_out_valid} !== 3'b010 || o_swap_count !== 8'd0) begin
      n_err++;
      $display("FAIL mid_sort_reset: got busy/rdy/vld %b swaps %0d want 010 0",
               {o_busy, o_in_ready, o_out_valid}, o_swap_count);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (o_out_valid !== 1'b0) begin
        n_err++; $display("FAIL discarded_burst: out_valid got %b want 0", o_out_valid);
      end
    end
    run_burst("after_reset", {8'd3, 8'd1, 8'd2, 8'd0}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_first",  {8'd10, 8'd20, 8'd30, 8'd40}, 1'b0, 1'b1, 3);
    run_burst("b2b_second", {8'd4, 8'd3, 8'd2, 8'd1},     1'b0, 1'b1, 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sort_patterns();
    test_backpressure();
    test_reset_mid_sort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
